i2c_slave: RTL and testbench

Single-address I2C target (responder) that sits on the same two-wire bus as the team's I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it. Write bytes are delivered on a one-cycle strobe; read bytes are requested from the local logic and shifted out. SDA is open-drain: the block only ever pulls low.

---
 rtl/i2c_slave_if.sv | 22 ++
 rtl/i2c_slave.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// I2C target bundle: bus pins plus the local write/read byte port.
// slave faces the target; master faces the bus and local logic.
interface i2c_slave_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  modport slave (
    input  scl, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_slave.sv
// Single-address oversampling I2C target; open-drain SDA.
// Define I2C_SLAVE_READ_EN to enable read transfers.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input logic        clk,
  input logic        reset,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_hist, sda_hist;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic       sda_bit;

  state_t     state, state_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [7:0] shreg, shreg_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] shift_in;
  logic       addr_ok;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // Idle bus is high, so reset the sampler high to avoid fake events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_hist <= scl_s;
      sda_hist <= sda_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      scl_rise  <= scl_s & ~scl_hist;
      scl_fall  <= ~scl_s & scl_hist;
      start_det <= scl_s & scl_hist
                 & sda_hist & ~sda_s;
      stop_det  <= scl_s & scl_hist
                 & ~sda_hist & sda_s;
      sda_bit   <= sda_s;
    end
  end

  assign shift_in = {shreg[6:0], sda_bit};

`ifdef I2C_SLAVE_READ_EN
  logic tx_req_q, tx_req_d;
  logic nack_q, nack_d;

  assign addr_ok = (shreg[7:1] == ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_req_q <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      tx_req_q <= tx_req_d;
      nack_q   <= nack_d;
    end
  end

  // bit7 must be on SDA in the same cycle tx_data is sampled.
  assign bus.sda_oe = tx_req_q ? ~bus.tx_data[7]
                               : sda_oe_q;
  assign bus.tx_req = tx_req_q;
`else
  logic unused_tx;

  assign addr_ok    = (shreg[7:1] == ADDR) & ~shreg[0];
  assign bus.sda_oe = sda_oe_q;
  assign bus.tx_req = 1'b0;
  assign unused_tx  = ^bus.tx_data;
`endif

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    tx_req_d   = 1'b0;
    nack_d     = nack_q;
`endif
    unique case (1'b1)
      stop_det: begin
        state_d  = ST_IDLE;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
      start_det: begin
        state_d   = ST_ADDR;
        sda_oe_d  = 1'b0;
        bit_cnt_d = '0;
      end
      default: begin
        unique case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (scl_rise) begin
              shreg_d   = shift_in;
              bit_cnt_d = bit_cnt + 4'd1;
            end
            if (scl_fall && bit_cnt == 4'd8) begin
              if (addr_ok) begin
                sda_oe_d = 1'b1;
                state_d  = ST_ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              busy_d    = 1'b1;
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
`ifdef I2C_SLAVE_READ_EN
              if (shreg[0]) begin
                state_d  = ST_READ;
                tx_req_d = 1'b1;
              end else begin
                state_d  = ST_WRITE;
              end
`else
              state_d = ST_WRITE;
`endif
            end
          end
          ST_WRITE: begin
            if (scl_rise) begin
              shreg_d   = shift_in;
              bit_cnt_d = bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rx_data_d  = shift_in;
                rx_valid_d = 1'b1;
              end
            end
            if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe_d = 1'b1;
              state_d  = ST_WRITE_ACK;
            end
          end
          ST_WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WRITE;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          ST_READ: begin
            if (tx_req_q) begin
              shreg_d   = bus.tx_data;
              sda_oe_d  = ~bus.tx_data[7];
              bit_cnt_d = '0;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe_d = 1'b0;
                state_d  = ST_READ_ACK;
              end else begin
                bit_cnt_d = bit_cnt + 4'd1;
                shreg_d   = {shreg[6:0], 1'b0};
                sda_oe_d  = ~shreg[6];
              end
            end
          end
          ST_READ_ACK: begin
            if (scl_rise)
              nack_d = sda_bit;
            if (scl_fall) begin
              if (nack_q) begin
                state_d = ST_WAIT_STOP;
              end else begin
                state_d  = ST_READ;
                tx_req_d = 1'b1;
              end
            end
          end
`endif
          ST_WAIT_STOP: sda_oe_d = 1'b0;
          default: begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master on a wired-AND SDA,
// expectations from a transaction-level model of the target.
module tb_i2c_slave;

`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam logic [6:0] TGT = 7'h50;

  logic clk = 1'b0;
  logic reset;
  logic scl_m, sda_m;

  always #5 clk = ~clk;

  i2c_slave_if bus ();

  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_slave #(.ADDR(TGT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_log [64];
  int rx_n = 0;
  int tx_n = 0;
  int oe_n = 0;
  int strobe_bad = 0;
  logic prev_rxv = 1'b0;
  logic prev_txr = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (rx_n < 64) rx_log[rx_n] = bus.rx_data;
      rx_n++;
    end
    if (bus.tx_req) tx_n++;
    if (bus.sda_oe) oe_n++;
    if ((bus.rx_valid && prev_rxv) ||
        (bus.tx_req && prev_txr) ||
        (bus.rx_valid && bus.tx_req))
      strobe_bad++;
    prev_rxv = bus.rx_valid;
    prev_txr = bus.tx_req;
  end

  logic [7:0] exp_rx [$];
  logic [7:0] wq [$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // A target ACKs its own address; reads only when built in.
  function automatic bit exp_ack(input logic [6:0] a,
                                 input bit rw);
    return (a == TGT) && (!rw || READ_EN);
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input bit b, output bit line);
    sda_m = b;
    wait_n(5);
    scl_m = 1'b1;
    wait_n(5);
    line = bus.sda_in;
    wait_n(5);
    scl_m = 1'b0;
    wait_n(5);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_n(5);
    scl_m = 1'b1;
    wait_n(5);
    sda_m = 1'b0;
    wait_n(5);
    scl_m = 1'b0;
    wait_n(5);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_n(5);
    scl_m = 1'b1;
    wait_n(5);
    sda_m = 1'b1;
    wait_n(10);
  endtask

  task automatic byte9(input logic [7:0] b, input bit m9,
                       output logic [7:0] obs, output bit l9);
    bit bl;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], bl);
      obs[i] = bl;
    end
    clock_bit(m9, l9);
  endtask

  task automatic write_txn(input logic [6:0] a, input bit stop);
    logic [7:0] o;
    bit l9, ack;
    int oe0;
    ack = exp_ack(a, 1'b0);
    oe0 = oe_n;
    start_cond();
    byte9({a, 1'b0}, 1'b1, o, l9);
    check("addr_ack", l9, !ack);
    check("busy_addr", bus.busy, ack);
    foreach (wq[i]) begin
      byte9(wq[i], 1'b1, o, l9);
      check("data_ack", l9, !ack);
      if (ack) exp_rx.push_back(wq[i]);
    end
    if (!ack) check("no_oe", oe_n - oe0, 0);
    if (stop) begin
      stop_cond();
      check("busy_stop", bus.busy, 0);
    end
  endtask

  task automatic check_rx();
    check("rx_cnt", rx_n, exp_rx.size());
    foreach (exp_rx[j])
      if (j < 64) check("rx_data", rx_log[j], exp_rx[j]);
  endtask

  initial begin
    logic [7:0] o, rd0, rd1;
    logic [6:0] a;
    bit l9, bl;
    int tx0, oe0;

    reset       = 1'b1;
    scl_m       = 1'b1;
    sda_m       = 1'b1;
    bus.tx_data = 8'h00;
    wait_n(4);
    check("rst_oe", bus.sda_oe, 0);
    check("rst_rxv", bus.rx_valid, 0);
    check("rst_txr", bus.tx_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rxd", bus.rx_data, 8'h00);
    reset = 1'b0;
    wait_n(10);

    // Reset asserted while the target drives the address ACK.
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      o = {TGT, 1'b0};
      clock_bit(o[i], bl);
    end
    sda_m = 1'b1;
    wait_n(5);
    check("ack_drive", bus.sda_oe, 1);
    scl_m = 1'b1;
    wait_n(2);
    reset = 1'b1;
    #1;
    check("mid_rst_oe", bus.sda_oe, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rxd", bus.rx_data, 8'h00);
    wait_n(3);
    reset = 1'b0;
    wait_n(10);

    wq = {8'($urandom)};
    write_txn(TGT, 1'b1);
    check_rx();

    wq = {8'hAA, 8'h3C};
    write_txn(TGT, 1'b1);
    check_rx();
    check("rx_hold", bus.rx_data, 8'h3C);

    wq = {8'hFF};
    write_txn(7'h51, 1'b1);
    check_rx();

    for (int t = 0; t < 4; t++) begin
      a = ($urandom_range(0, 1) == 1) ? TGT
                                      : 7'($urandom);
      wq = {};
      for (int k = $urandom_range(1, 3); k > 0; k--)
        wq.push_back(8'($urandom));
      write_txn(a, 1'b1);
      check_rx();
    end

    // Read: ACK first byte, NACK second.
    rd0 = 8'hA5;
    rd1 = 8'h5A;
    tx0 = tx_n;
    bus.tx_data = rd0;
    start_cond();
    byte9({TGT, 1'b1}, 1'b1, o, l9);
    check("rd_addr_ack", l9, !exp_ack(TGT, 1'b1));
    if (READ_EN) begin
      for (int i = 7; i >= 0; i--) begin
        clock_bit(1'b1, bl);
        o[i] = bl;
      end
      check("rd_byte0", o, rd0);
      bus.tx_data = rd1;
      clock_bit(1'b0, bl);
      for (int i = 7; i >= 0; i--) begin
        clock_bit(1'b1, bl);
        o[i] = bl;
      end
      check("rd_byte1", o, rd1);
      clock_bit(1'b1, bl);
      check("rd_txreq", tx_n - tx0, 2);
    end
    oe0 = oe_n;
    byte9(8'hFF, 1'b1, o, l9);
    check("rd_released", oe_n - oe0, 0);
    if (!READ_EN) check("rd_no_txreq", tx_n - tx0, 0);
    stop_cond();
    check("rd_busy_stop", bus.busy, 0);

    // Write then repeated START into a read.
    wq = {8'h11};
    write_txn(TGT, 1'b0);
    check_rx();
    check("rs_rxd", bus.rx_data, 8'h11);
    rd0 = 8'($urandom);
    bus.tx_data = rd0;
    tx0 = tx_n;
    start_cond();
    byte9({TGT, 1'b1}, 1'b1, o, l9);
    check("rs_addr_ack", l9, !exp_ack(TGT, 1'b1));
    if (READ_EN) begin
      byte9(8'hFF, 1'b1, o, l9);
      check("rs_rd_byte", o, rd0);
      check("rs_txreq", tx_n - tx0, 1);
    end else begin
      check("rs_no_txreq", tx_n - tx0, 0);
    end
    stop_cond();
    check("rs_busy_stop", bus.busy, 0);
    check("strobes", strobe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
